// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side slave for the CPU data SRAM port.
// Each request goes either to a word-addressed on-chip RAM or to the confreg
// register file (timer, LED, seven-segment number, switches, simulation flag).
// Read data is registered and appears the cycle after the request.
module data_sram_responder #(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [15:0] CONF_HI = 16'hbfaf,
    parameter logic        SIMU    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned DEPTH     = 1 << RAM_AW;

    localparam logic [15:0] OFF_TIMER = 16'he000;
    localparam logic [15:0] OFF_LED   = 16'hf000;
    localparam logic [15:0] OFF_NUM   = 16'hf010;
    localparam logic [15:0] OFF_SW    = 16'hf020;
    localparam logic [15:0] OFF_SIMU  = 16'hffec;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              conf;
        logic [15:0]       off;
        logic [RAM_AW-1:0] idx;
        logic [NUM_LANES-1:0] wen;
        logic [NUM_LANES-1:0][LANE_W-1:0] wdata;
    } req_t;

    req_t req;

    logic [31:0] timer;
    logic [15:0] led;
    logic [31:0] num;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    logic [NUM_LANES-1:0][LANE_W-1:0] ram_q;
    logic [31:0] conf_rd;
    logic [31:0] conf_q;
    logic        sel_ram;

    logic ram_wr;
    logic ram_rd;
    logic conf_wr;

    // The byte offset bits never select anything.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Decode the incoming request into class, target and RAM index.
    always_comb begin
        req       = '0;
        req.rd    = data_sram_en && (data_sram_wen == 4'h0);
        req.wr    = data_sram_en && (data_sram_wen != 4'h0);
        req.conf  = (data_sram_addr[31:16] == CONF_HI);
        req.off   = data_sram_addr[15:0];
        req.idx   = data_sram_addr[RAM_AW+1:2];
        req.wen   = data_sram_wen;
        req.wdata = data_sram_wdata;
    end

    assign ram_wr  = req.wr && !req.conf;
    assign ram_rd  = req.rd && !req.conf;
    // Confreg registers only accept full-word writes.
    assign conf_wr = req.wr && req.conf && (req.wen == 4'hf);

    // One byte-wide RAM per lane; read-first because the read samples the old word.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] q;

        // Lane write under its enable, registered read on RAM read requests.
        always_ff @(posedge clk) begin
            if (ram_wr && req.wen[g]) begin
                mem[req.idx] <= req.wdata[g];
            end
            if (ram_rd) begin
                q <= mem[req.idx];
            end
        end

        assign ram_q[g] = q;
    end

    // Free-running timer; a software write overrides the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 32'h0;
        end else if (conf_wr && (req.off == OFF_TIMER)) begin
            timer <= req.wdata;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // LED and NUM writable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= 16'hffff;
            num <= 32'h0;
        end else if (conf_wr) begin
            if (req.off == OFF_LED) begin
                led <= req.wdata[15:0];
            end
            if (req.off == OFF_NUM) begin
                num <= req.wdata;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= 8'h0;
            sw_sync <= 8'h0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
        end
    end

    // Confreg read mux; unmapped offsets read as zero.
    always_comb begin
        conf_rd = 32'h0;
        case (req.off)
            OFF_TIMER: conf_rd = timer;
            OFF_LED:   conf_rd = {16'h0, led};
            OFF_NUM:   conf_rd = num;
            OFF_SW:    conf_rd = {24'h0, sw_sync};
            OFF_SIMU:  conf_rd = {31'h0, SIMU};
            default:   conf_rd = 32'h0;
        endcase
    end

    // Read-return select and confreg capture; only reads move these, so rdata holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_ram <= 1'b0;
            conf_q  <= 32'h0;
        end else if (req.rd) begin
            sel_ram <= !req.conf;
            if (req.conf) begin
                conf_q <= conf_rd;
            end
        end
    end

    assign data_sram_rdata = sel_ram ? ram_q : conf_q;
    assign led_out         = led;
    assign num_out         = num;

endmodule
